// File: rtl/gcd_arb_pkg.sv
// gcd_arb_pkg
// Shared types and default sizing for the GCD arbiter slice.
//   arb_state_e : arbiter FSM state encoding
//   DEF_OP_SZ   : default operand/result width
//   DEF_N_REQ   : default number of requesters
package gcd_arb_pkg;

  localparam int DEF_OP_SZ = 8;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/gcd_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin selector: picks the first set request bit at or
// after ptr, searching cyclically.
// Ports:
//   req      in  N_REQ  request vector
//   ptr      in  ID_W   highest-priority index
//   gnt      out N_REQ  one-hot grant (all zero when no request)
//   gnt_idx  out ID_W   index of the granted bit
//   req_any  out 1      at least one request is set
import gcd_arb_pkg::*;

module rr_picker #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             req_any
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    req_any = |req;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt[cand]   = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Round-robin scheduler sharing one GCD core among N_REQ requesters. One job
// in flight at a time: grant in IDLE, load the core, wait for core_done, then
// hold the response until the consumer takes it.
// Optional feature macro: GCD_ARB_ZERO_BYPASS_EN -- a job with a zero operand
// skips the core and answers with the nonzero operand (or 0).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot, IDLE only)
//   req_a, req_b          packed operands, requester i at [i*OP_SZ +: OP_SZ]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_res       answered requester and its result
//   core_a, core_b        operands to the core
//   core_load, core_start core control (load pulse, start level)
//   core_res, core_done   core result and done level
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for any request; grant and latch operands
// LOAD    | pulse core_load with latched operands
// RUN     | core computing; capture core_res on core_done
// RESP    | rsp_valid held until rsp_ready; then advance rr_ptr
import gcd_arb_pkg::*;

module gcd_arbiter #(
  parameter int OP_SZ = DEF_OP_SZ,
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*OP_SZ-1:0] req_a,
  input  logic [N_REQ*OP_SZ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [OP_SZ-1:0]       rsp_res,
  output logic [OP_SZ-1:0]       core_a,
  output logic [OP_SZ-1:0]       core_b,
  output logic                   core_load,
  output logic                   core_start,
  input  logic [OP_SZ-1:0]       core_res,
  input  logic                   core_done
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  gnt_q;
  logic [OP_SZ-1:0] a_q, b_q, res_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [OP_SZ-1:0] a_arr [N_REQ];
  logic [OP_SZ-1:0] b_arr [N_REQ];
  logic [OP_SZ-1:0] sel_a, sel_b;
  logic             take_bypass;
  logic             grant;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*OP_SZ +: OP_SZ];
    assign b_arr[gi] = req_b[gi*OP_SZ +: OP_SZ];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .req_any (pick_any)
  );

  assign sel_a = a_arr[pick_idx];
  assign sel_b = b_arr[pick_idx];

`ifdef GCD_ARB_ZERO_BYPASS_EN
  assign take_bypass = (sel_a == '0) || (sel_b == '0);
`else
  assign take_bypass = 1'b0;
`endif

  // A grant is never offered while reset is asserted: the requester would
  // drop its request for a job the arbiter is about to forget.
  assign grant = (state_q == ST_IDLE) && pick_any && !rst;

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    core_load  = 1'b0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          req_ready = pick_gnt;
          state_d   = take_bypass ? ST_RESP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_load  = 1'b1;
        core_start = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        core_start = 1'b1;
        if (core_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            gnt_q <= pick_idx;
            a_q   <= sel_a;
            b_q   <= sel_b;
            // With one operand zero, OR yields the other one (or 0 for both).
            if (take_bypass) res_q <= sel_a | sel_b;
          end
        end
        ST_RUN: begin
          if (core_done) res_q <= core_res;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rr_ptr_q <= (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign core_a  = a_q;
  assign core_b  = b_q;
  assign rsp_id  = gnt_q;
  assign rsp_res = res_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter
// Directed bench for gcd_arbiter with a behavioural GCD core model.
module tb_gcd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_res, core_a, core_b, core_res;
  logic        core_load, core_start, core_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gcd_arbiter #(.OP_SZ(8), .N_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_load  (core_load),
    .core_start (core_start),
    .core_res   (core_res),
    .core_done  (core_done)
  );

  // Behavioural core: result ready three cycles after the load.
  function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  logic [7:0] m_res;
  int         m_cnt;
  logic       m_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (core_load) begin
      m_res  <= gcd8(core_a, core_b);
      m_cnt  <= 3;
      m_busy <= 1'b1;
    end else if (m_busy && core_start && m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign core_done = m_busy && (m_cnt == 0);
  assign core_res  = m_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready), 0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},     32'(rsp_id), 0);
    chk({tag, "_rsp_res"},    32'(rsp_res), 0);
    chk({tag, "_core_a"},     32'(core_a), 0);
    chk({tag, "_core_b"},     32'(core_b), 0);
    chk({tag, "_core_load"},  32'(core_load), 0);
    chk({tag, "_core_start"}, 32'(core_start), 0);
  endtask

  // Raise one request, expect the grant in this IDLE cycle, drop after it.
  task automatic grant_one(input int i, input logic [7:0] a, input logic [7:0] b);
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 32'(1) << i);
    step();
    req_valid[i] = 1'b0;
    #1;
  endtask

  // Wait for rsp_valid; the cycle before it, core_done must have been high.
  task automatic wait_rsp(input string tag);
    logic prev;
    prev = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) break;
      prev = core_done;
      step();
    end
    chk({tag, "_rsp_timeout"}, 32'(rsp_valid), 1);
    chk({tag, "_done_latency"}, 32'(prev), 1);
  endtask

  task automatic zero_job(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp);
    grant_one(i, a, b);
`ifdef GCD_ARB_ZERO_BYPASS_EN
    chk("zb_rsp_valid", 32'(rsp_valid), 1);
    chk("zb_rsp_res", 32'(rsp_res), 32'(exp));
    chk("zb_rsp_id", 32'(rsp_id), 32'(i));
    chk("zb_core_load", 32'(core_load), 0);
    chk("zb_core_start", 32'(core_start), 0);
`else
    chk("zc_core_load", 32'(core_load), 1);
    wait_rsp("zc");
    chk("zc_rsp_res", 32'(rsp_res), 32'(exp));
    chk("zc_rsp_id", 32'(rsp_id), 32'(i));
`endif
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         n;
    int         g;
    logic [3:0] rr;
    logic [1:0] ids  [4];
    logic [7:0] ress [4];
    int         gids [4];
    int         exp_res [4];
    logic       seen;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset();

    // Reset state
    chk_all_zero("rst");

    // Single request (25,15) from req 0
    grant_one(0, 8'd25, 8'd15);
    chk("t1_load", 32'(core_load), 1);
    chk("t1_start", 32'(core_start), 1);
    chk("t1_core_a", 32'(core_a), 25);
    chk("t1_core_b", 32'(core_b), 15);
    chk("t1_no_ready", 32'(req_ready), 0);
    step();
    chk("t1_load_pulse", 32'(core_load), 0);
    chk("t1_run_start", 32'(core_start), 1);
    wait_rsp("t1");
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_rsp_res", 32'(rsp_res), 5);
    step();
    chk("t1_rsp_done", 32'(rsp_valid), 0);

    // All four at once, pointer 0
    do_reset();
    set_op(0, 8'd12, 8'd9);
    set_op(1, 8'd12, 8'd8);
    set_op(2, 8'd25, 8'd15);
    set_op(3, 8'd7,  8'd3);
    exp_res = '{3, 4, 5, 1};
    req_valid = 4'hF;
    #1;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < 4; cyc++) begin
      rr = req_ready;
      if (rsp_valid) begin
        ids[n]  = rsp_id;
        ress[n] = rsp_res;
        n++;
      end
      step();
      req_valid = req_valid & ~rr;
      #1;
    end
    chk("t2_count", 32'(n), 4);
    for (int i = 0; i < n; i++) begin
      chk("t2_id", 32'(ids[i]), 32'(i));
      chk("t2_res", 32'(ress[i]), 32'(exp_res[i]));
    end

    // Req 1 and 2 continuously: grants alternate
    set_op(1, 8'd12, 8'd8);
    set_op(2, 8'd25, 8'd15);
    req_valid = 4'b0110;
    #1;
    g = 0;
    for (int cyc = 0; cyc < 400 && g < 4; cyc++) begin
      if (req_ready != 0) begin
        for (int b = 0; b < 4; b++) if (req_ready[b]) gids[g] = b;
        g++;
      end
      step();
    end
    chk("t3_count", 32'(g), 4);
    chk("t3_g0", 32'(gids[0]), 1);
    chk("t3_g1", 32'(gids[1]), 2);
    chk("t3_g2", 32'(gids[2]), 1);
    chk("t3_g3", 32'(gids[3]), 2);
    req_valid = '0;
    do_reset();

    // Back-pressure on the response
    rsp_ready = 1'b0;
    grant_one(3, 8'd7, 8'd3);
    wait_rsp("t4");
    set_op(0, 8'd12, 8'd8);
    req_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 1);
      chk("t4_hold_id", 32'(rsp_id), 3);
      chk("t4_hold_res", 32'(rsp_res), 1);
      chk("t4_hold_noready", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_still_valid", 32'(rsp_valid), 1);
    step();
    chk("t4_released", 32'(rsp_valid), 0);
    chk("t4_next_grant", 32'(req_ready), 1);
    step();
    req_valid[0] = 1'b0;
    #1;
    wait_rsp("t4b");
    chk("t4b_id", 32'(rsp_id), 0);
    chk("t4b_res", 32'(rsp_res), 4);
    step();

    // Reset during RUN (pointer is 1 beforehand)
    grant_one(2, 8'd25, 8'd15);
    step();
    chk("t5_in_run", 32'(core_start), 1);
    chk("t5_in_run_load", 32'(core_load), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("t5");
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) seen = 1'b1;
      step();
    end
    chk("t5_no_rsp", 32'(seen), 0);
    set_op(0, 8'd25, 8'd15);
    set_op(2, 8'd12, 8'd9);
    req_valid = 4'b0101;
    #1;
    chk("t5_ptr_reset", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    wait_rsp("t5");
    chk("t5_id", 32'(rsp_id), 0);
    chk("t5_res", 32'(rsp_res), 5);
    step();

    // Zero operands (pointer is 1)
    zero_job(1, 8'd12, 8'd0, 8'd12);
    zero_job(2, 8'd0, 8'd9, 8'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
